// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory load/store interface: operation
// encodings and the request legality check applied at acceptance time.
package mem_pkg;

  typedef enum logic [2:0] {
    OP_BYTE   = 3'b000,
    OP_HALF   = 3'b001,
    OP_WORD   = 3'b010,
    OP_BYTE_U = 3'b011,
    OP_HALF_U = 3'b100
  } mem_op_e;

  // A request is illegal when misaligned for its size, when it uses a
  // reserved encoding, or when it is a store with an unsigned variant.
  function automatic logic req_is_error(input logic       is_write,
                                        input logic [2:0] op,
                                        input logic [1:0] offset);
    logic err;
    case (op)
      OP_BYTE:   err = 1'b0;
      OP_HALF:   err = offset[0];
      OP_WORD:   err = (offset != 2'b00);
      OP_BYTE_U: err = is_write;
      OP_HALF_U: err = is_write | offset[0];
      default:   err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port word RAM with synchronous read and write. A cycle either
// writes or reads, never both, so the read port holds its last value
// during writes.
module data_ram #(
  parameter int AW = 15,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Write when enabled, otherwise register the addressed word.
  // NOTE: the array has no reset; clearing it would cost a write per word
  // and a RAM macro cannot do it, so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end else begin
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_controller.sv
// Memory-side responder for load/store requests. Accepts one request at a
// time, performs sub-word stores as read-modify-write on data_ram and
// returns exactly one response per request.
module data_mem_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrite,
  input  logic [2:0]            MemoryOp,
  input  logic [ADDR_WIDTH-1:0] ReqAddr,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic                  RespValid,
  input  logic                  RespReady,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  RespError
);
  import mem_pkg::*;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_MRG, S_WR, S_RESP} state_e;

  state_e                  state_q, state_d;
  logic                    write_q, write_d;
  logic [2:0]              op_q, op_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;
  logic                    resp_error_q, resp_error_d;

  logic                    accept;
  logic                    req_err;
  logic                    ram_we;
  logic [DATA_WIDTH-1:0]   ram_din, ram_dout;
  logic [7:0]              lane_byte;
  logic [15:0]             lane_half;
  logic [DATA_WIDTH-1:0]   load_value, merged_word;

  assign ReqReady  = rst_n && (state_q == S_IDLE);
  assign accept    = ReqValid && ReqReady;
  assign req_err   = req_is_error(ReqWrite, MemoryOp, ReqAddr[1:0]);
  assign RespValid = resp_valid_q;
  assign ReadData  = read_data_q;
  assign RespError = resp_error_q;

  // Writes happen only in MRG (stores) or WR; rst_n gates the enable so an
  // interrupted store never reaches the array.
  assign ram_we  = rst_n && (((state_q == S_MRG) && write_q) || (state_q == S_WR));
  assign ram_din = (state_q == S_WR) ? wdata_q : merged_word;

  data_ram #(.AW(ADDR_WIDTH-2), .DW(DATA_WIDTH)) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (addr_q[ADDR_WIDTH-1:2]),
    .din  (ram_din),
    .dout (ram_dout)
  );

  // Lane extraction for loads and lane merge for sub-word stores.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    lane_byte   = ram_dout[{addr_q[1:0], 3'b000} +: 8];
    lane_half   = ram_dout[{addr_q[1], 4'b0000} +: 16];
    load_value  = ram_dout;
    merged_word = ram_dout;
    case (op_q)
      OP_BYTE: begin
        load_value = {{(DATA_WIDTH-8){lane_byte[7]}}, lane_byte};
        merged_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      OP_HALF: begin
        load_value = {{(DATA_WIDTH-16){lane_half[15]}}, lane_half};
        merged_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      OP_BYTE_U: load_value = {{(DATA_WIDTH-8){1'b0}}, lane_byte};
      OP_HALF_U: load_value = {{(DATA_WIDTH-16){1'b0}}, lane_half};
      default:   load_value = ram_dout;
    endcase
  end

  // Next-state and registered-output logic of the request FSM.
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    read_data_d  = read_data_q;
    resp_error_d = resp_error_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          write_d      = ReqWrite;
          op_d         = MemoryOp;
          addr_d       = ReqAddr;
          wdata_d      = WriteData;
          read_data_d  = '0;
          resp_error_d = req_err;
          if (req_err) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
          end else if (ReqWrite && (MemoryOp == OP_WORD)) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: state_d = S_MRG;
      S_MRG: begin
        if (!write_q) read_data_d = load_value;
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
      end
      S_WR: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
      end
      S_RESP: begin
        if (RespReady) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      op_q         <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      read_data_q  <= '0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      read_data_q  <= read_data_d;
      resp_error_q <= resp_error_d;
    end
  end

endmodule

// File: tb/tb_data_mem_controller.sv
// Directed bench for data_mem_controller: latency, lane extraction,
// read-modify-write stores, error responses, backpressure and mid-store reset.
module tb_data_mem_controller;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ReqValid, ReqReady, ReqWrite;
  logic [2:0]  MemoryOp;
  logic [16:0] ReqAddr;
  logic [31:0] WriteData;
  logic        RespValid, RespReady;
  logic [31:0] ReadData;
  logic        RespError;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  data_mem_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(17)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ReqValid  (ReqValid),
    .ReqReady  (ReqReady),
    .ReqWrite  (ReqWrite),
    .MemoryOp  (MemoryOp),
    .ReqAddr   (ReqAddr),
    .WriteData (WriteData),
    .RespValid (RespValid),
    .RespReady (RespReady),
    .ReadData  (ReadData),
    .RespError (RespError)
  );

  // Issue one request with RespReady high; report response latency
  // (acceptance cycle = 0) and the response payload.
  task automatic do_req(input logic wr, input logic [2:0] op, input logic [16:0] addr,
                        input logic [31:0] wd, output int lat,
                        output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    ReqValid = 1'b1; ReqWrite = wr; MemoryOp = op; ReqAddr = addr; WriteData = wd;
    RespReady = 1'b1;
    n = 0;
    while (ReqReady !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      miscompares++;
      $display("FAIL req_accept_timeout: ReqReady=%b required 1", ReqReady);
    end
    @(negedge clk);
    // Scramble the request inputs: they must be ignored once accepted.
    ReqValid = 1'b0; ReqWrite = ~wr; MemoryOp = 3'b111; ReqAddr = 17'h1FFFF;
    WriteData = 32'h5A5A_5A5A;
    lat = 1;
    while (RespValid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) begin
      miscompares++;
      $display("FAIL resp_timeout: RespValid=%b required 1", RespValid);
    end
    rd = ReadData;
    er = RespError;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; MemoryOp = 3'b000;
    ReqAddr = '0; WriteData = '0; RespReady = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({ReqReady, RespValid, RespError, ReadData} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: rdy=%b vld=%b err=%b data=%h required all 0",
               ReqReady, RespValid, RespError, ReadData);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (ReqReady !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b required 1", ReqReady);
    end
  endtask

  task automatic test_word();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b1, OP_WORD, 17'h10000, 32'hDEADBEEF, lat, rd, er);
    vectors++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h0) begin
      miscompares++;
      $display("FAIL word_store: lat=%0d err=%b data=%h required 2/0/00000000", lat, er, rd);
    end
    do_req(1'b0, OP_WORD, 17'h10000, 32'h0, lat, rd, er);
    vectors++;
    if (lat !== 3 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL word_load: lat=%0d err=%b data=%h required 3/0/deadbeef", lat, er, rd);
    end
  endtask

  task automatic test_subword_loads();
    logic [2:0]  ops  [4] = '{OP_BYTE, OP_BYTE_U, OP_HALF, OP_HALF_U};
    logic [16:0] adrs [4] = '{17'h10003, 17'h10003, 17'h10002, 17'h10000};
    logic [31:0] exps [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
    int lat; logic [31:0] rd; logic er;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, ops[i], adrs[i], 32'h0, lat, rd, er);
      vectors++;
      if (lat !== 3 || er !== 1'b0 || rd !== exps[i]) begin
        miscompares++;
        $display("FAIL subword_load_%0d: lat=%0d err=%b data=%h required 3/0/%h",
                 i, lat, er, rd, exps[i]);
      end
    end
  endtask

  task automatic test_subword_stores();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b1, OP_BYTE, 17'h10001, 32'hAAAAAA12, lat, rd, er);
    vectors++;
    if (lat !== 3 || er !== 1'b0 || rd !== 32'h0) begin
      miscompares++;
      $display("FAIL byte_store: lat=%0d err=%b data=%h required 3/0/00000000", lat, er, rd);
    end
    do_req(1'b0, OP_WORD, 17'h10000, 32'h0, lat, rd, er);
    vectors++;
    if (rd !== 32'hDEAD12EF) begin
      miscompares++;
      $display("FAIL byte_store_merge: got %h required dead12ef", rd);
    end
    do_req(1'b1, OP_HALF, 17'h10002, 32'h00005678, lat, rd, er);
    do_req(1'b0, OP_WORD, 17'h10000, 32'h0, lat, rd, er);
    vectors++;
    if (rd !== 32'h567812EF) begin
      miscompares++;
      $display("FAIL half_store_merge: got %h required 567812ef", rd);
    end
  endtask

  task automatic test_errors();
    logic        wrs  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0]  ops  [4] = '{OP_WORD, OP_HALF, OP_BYTE_U, 3'b101};
    logic [16:0] adrs [4] = '{17'h10002, 17'h10001, 17'h10000, 17'h10000};
    int lat; logic [31:0] rd; logic er;
    for (int i = 0; i < 4; i++) begin
      do_req(wrs[i], ops[i], adrs[i], 32'hFFFFFFFF, lat, rd, er);
      vectors++;
      if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
        miscompares++;
        $display("FAIL error_req_%0d: lat=%0d err=%b data=%h required 1/1/00000000",
                 i, lat, er, rd);
      end
    end
    do_req(1'b0, OP_WORD, 17'h10000, 32'h0, lat, rd, er);
    vectors++;
    if (rd !== 32'h567812EF) begin
      miscompares++;
      $display("FAIL error_mem_unchanged: got %h required 567812ef", rd);
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    ReqValid = 1'b1; ReqWrite = 1'b0; MemoryOp = OP_HALF_U; ReqAddr = 17'h10000;
    WriteData = '0; RespReady = 1'b0;
    @(negedge clk);
    ReqValid = 1'b0;
    n = 1;
    while (RespValid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (RespValid !== 1'b1 || ReadData !== 32'h000012EF || ReqReady !== 1'b0) begin
        miscompares++;
        $display("FAIL backpressure_hold_%0d: vld=%b data=%h rdy=%b required 1/000012ef/0",
                 i, RespValid, ReadData, ReqReady);
      end
      @(negedge clk);
    end
    RespReady = 1'b1;
    @(negedge clk);
    vectors++;
    if (ReqReady !== 1'b1 || RespValid !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure_release: rdy=%b vld=%b required 1/0", ReqReady, RespValid);
    end
  endtask

  task automatic test_mid_reset();
    int lat; logic [31:0] rd; logic er;
    @(negedge clk);
    ReqValid = 1'b1; ReqWrite = 1'b1; MemoryOp = OP_BYTE; ReqAddr = 17'h10000;
    WriteData = 32'h00000077; RespReady = 1'b1;
    @(negedge clk);                  // RD
    ReqValid = 1'b0;
    @(negedge clk);                  // MRG
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({ReqReady, RespValid, RespError, ReadData} !== 35'd0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: rdy=%b vld=%b err=%b data=%h required all 0",
               ReqReady, RespValid, RespError, ReadData);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (ReqReady !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_ready: got %b required 1", ReqReady);
    end
    do_req(1'b0, OP_WORD, 17'h10000, 32'h0, lat, rd, er);
    vectors++;
    if (rd !== 32'h567812EF) begin
      miscompares++;
      $display("FAIL mid_reset_mem: got %h required 567812ef", rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word();
    test_subword_loads();
    test_subword_stores();
    test_errors();
    test_backpressure();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem_controller.md
# data_mem_controller

Sequential responder on the memory side of the data-memory load/store interface. It accepts one load or store request at a time over a valid/ready handshake and performs byte-lane extraction using address offsets. Sub-word stores run as a read-modify-write on a single-port, synchronous-read word RAM. Each request returns exactly one response on a second valid/ready channel, with an error flag for misaligned or illegal requests.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data word width; only 32 is supported.
- `ADDR_WIDTH`, 17, byte-address width; the RAM holds 2**(ADDR_WIDTH-2) words.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `ReqValid`  in  1  request present.
- `ReqReady`  out  1  controller can accept; high only in IDLE.
- `ReqWrite`  in  1  1 = store, 0 = load.
- `MemoryOp`  in  3  BYTE=000, HALF=001, WORD=010, BYTE_UNSIGNED=011, HALF_UNSIGNED=100.
- `ReqAddr`  in  ADDR_WIDTH  byte address.
- `WriteData`  in  DATA_WIDTH  store data, right-aligned.
- `RespValid`  out  1  response present.
- `RespReady`  in  1  consumer accepts the response.
- `ReadData`  out  DATA_WIDTH  load result; 0 for stores and errors.
- `RespError`  out  1  request was rejected; no RAM access took place.

## Operation
- Request and response transfers each occur on a cycle where valid && ready. On acceptance, ReqWrite, MemoryOp, ReqAddr and WriteData are latched. Inputs are ignored outside acceptance.
- Word index = addr[ADDR_WIDTH-1:2]. Memory is little-endian:
  - byte lane = addr[1:0];
  - half lane = addr[1].
- Error conditions are checked at acceptance:
  - HALF or HALF_UNSIGNED with addr[0]=1;
  - WORD with addr[1:0]≠0;
  - MemoryOp in 101–111;
  - a store with BYTE_UNSIGNED or HALF_UNSIGNED.
- Loads:
  - Extract the addressed byte or half from the read word.
  - BYTE and HALF results are sign-extended.
  - BYTE_UNSIGNED and HALF_UNSIGNED results are zero-extended.
- Sub-word stores read the word, replace only the addressed lane with WriteData[7:0] or WriteData[15:0], and write the merged word back. A WORD store writes WriteData directly, with no read.
- FSM states: IDLE, RD, MRG, WR, RESP.
  - IDLE, on acceptance, goes to:
    - RESP if the request is an error (RespError=1);
    - WR if it is a WORD store;
    - RD otherwise.
  - RD: issue the RAM read; next state is MRG.
  - MRG: RAM data is valid. For a load, register ReadData. For a store, write the merged word. Next state is RESP.
  - WR: write the full word; next state is RESP.
  - RESP: RespValid=1. Go to IDLE when RespReady=1.
- In RESP, ReadData and RespError are held stable until the handshake.
- Only one request is in flight. There is no pipelining.

## Timing
- Reset (rst_n=0 at a rising edge):
  - state goes to IDLE; RespValid=0, ReadData=0, RespError=0;
  - ReqReady is forced to 0 while rst_n=0;
  - RAM write-enable is gated by rst_n, so a store interrupted in MRG or WR leaves memory unchanged;
  - RAM contents are not cleared.
- ReqReady=1 in the first cycle after reset release.
- Cycle counts below take the acceptance cycle as cycle 0. RespValid first goes high in:
  - cycle 3 for loads and sub-word stores;
  - cycle 2 for WORD stores;
  - cycle 1 for errors.
- ReqReady returns the cycle after the response handshake. Peak throughput is therefore one load per 4 cycles when RespReady is held high.
- The RAM has a one-cycle synchronous read. Read and write never occur in the same cycle.
- ReqValid asserted during a busy state has no effect. The requester must hold the request until ReqReady.

## Structure
- The memory_operation enum (`MemoryOp` encodings) goes in the shared package `mem_pkg`, together with the load/store parsing logic. The FSM state enum stays local to this block.
- One sub-module, `data_ram`: single-port, 2**(ADDR_WIDTH-2)×32, synchronous read and write, with inputs `clk`, `we`, `addr`, `din` and output `dout`.
- Lane extraction and merge logic is combinational inside `data_mem_controller`.

## Test plan
- WORD store of 0xDEADBEEF to 0x10000, then WORD load from 0x10000: RespValid in cycle 2, then cycle 3; ReadData=0xDEADBEEF; RespError=0.
- Loads from the same word:
  - BYTE at 0x10003 → 0xFFFFFFDE;
  - BYTE_UNSIGNED at 0x10003 → 0x000000DE;
  - HALF at 0x10002 → 0xFFFFDEAD;
  - HALF_UNSIGNED at 0x10000 → 0x0000BEEF.
- Sub-word stores to the same word:
  - BYTE store of WriteData 0xAAAAAA12 to 0x10001 → word reads 0xDEAD12EF;
  - then HALF store of 0x00005678 to 0x10002 → word reads 0x567812EF.
- Error requests:
  - WORD load at 0x10002 → RespValid in cycle 1, RespError=1, ReadData=0;
  - HALF store at 0x10001 → same response, and memory is unchanged.
- Backpressure: hold RespReady low for 5 cycles during a load. RespValid and ReadData stay stable, and ReqReady stays 0. ReqReady rises one cycle after RespReady is raised.
- Mid-operation reset: pull rst_n low while in MRG of a BYTE store to 0x10000. Memory word is unchanged, all outputs are 0, and ReqReady=1 in the first cycle after release.
